piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in serial-out transmitter with a word-level valid/ready handshake.
- Accepts a WIDTH-bit word and shifts it out one bit per clock, marking the first bit of each frame.
- Serves as the transmit end for the team's 4-bit parallel register and deserializer path.
- Supports gapless back-to-back words so a downstream SIPO sees a continuous bit stream.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- parallel_in  input  WIDTH  word to transmit; sampled only on an accept edge.
- load_valid  input  1  upstream has a word on parallel_in.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a valid data bit.
- frame_start  output  1  high only while the first bit of a word is on serial_out.
- busy  output  1  high while a word is in flight (equals serial_valid).

Behaviour:
- State: FSM {IDLE, SHIFT}, shift register shreg[WIDTH-1:0], bit counter cnt[clog2(WIDTH)-1:0].
- Reset (asynchronous, immediate, including mid-frame):
  - state=IDLE, shreg=0, cnt=0.
  - serial_out=0, serial_valid=0, frame_start=0, busy=0, load_ready=1.
  - The partially sent word is discarded; no completion is signalled.
- Accept: a word is accepted on a rising edge where load_valid && load_ready.
  - shreg <= parallel_in, cnt <= 0, state <= SHIFT.
- Handshake:
  - load_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1).
  - load_valid while load_ready=0 is ignored; the bench must not see shreg change.
  - parallel_in changes after an accept have no effect on the word in flight.
- Latency: word accepted at edge N -> first bit on serial_out in the cycle after edge N.
  - Last bit of the word is on serial_out during the cycle after edge N+WIDTH-1.
- Outputs in SHIFT:
  - serial_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - serial_valid=1, busy=1, frame_start=(cnt==0).
  - Each non-final edge: shreg shifts toward the output end (MSB_FIRST: left; else: right), zero-filled; cnt += 1.
- Outputs in IDLE: serial_out=0, serial_valid=0, frame_start=0.
- Final bit (cnt==WIDTH-1), next-edge behaviour:
  - With accept: reload shreg, cnt=0, stay in SHIFT. Next word follows with no gap cycle and frame_start=1.
  - Without accept: state=IDLE, cnt=0, shreg=0.
- Counter never exceeds WIDTH-1; no wrap while in IDLE.
- Reset and load_valid asserted together: reset wins, nothing is accepted.
- Reset deassertion: first accept is possible on the first rising edge after reset falls.

Decomposition:
- Shared package/header:
  - State encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - clog2 function for counter width.
  - Default WIDTH=4 constant shared with the parallel-register and SIPO blocks.
- Sub-module mod_counter (parameter MOD):
  - Inputs: clear, enable.
  - Outputs: count, at_max.
  - Same clock and asynchronous active-high reset as the parent.
  - Instantiated once for cnt; reusable by the SIPO receiver.

Test Plan:
1. Reset behaviour: assert reset for 10 ns with load_valid=1 and parallel_in=4'b1111 -> all outputs 0, load_ready=1, nothing accepted. Release reset -> still IDLE.
2. Single word, MSB_FIRST=1: load 4'b1010 for one cycle -> serial_out 1,0,1,0 on the 4 following cycles. serial_valid high exactly 4 cycles; frame_start high only on the first; then load_ready=1 and serial_valid=0.
3. Back-to-back: present 4'b1010, then hold load_valid with 4'b0101 until accepted on the cnt==3 edge -> 8 contiguous bits 1,0,1,0,0,1,0,1. serial_valid never drops; frame_start pulses at bit 0 and bit 4.
4. Ignored load: while sending 4'b1100, pulse load_valid with 4'b0011 at cnt==1 -> stream stays 1,1,0,0; the 0011 word is never transmitted.
5. Reset mid-frame: load 4'b1111, assert reset asynchronously (off-edge) during bit 2 -> serial_out and serial_valid drop to 0 immediately. After release, loading 4'b0001 yields 0,0,0,1.
6. LSB-first: MSB_FIRST=0, load 4'b1010 -> serial_out 0,1,0,1. Also run with WIDTH=8 and 8'hA5 -> 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/piso_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_pkg
// Purpose  : Shared types and helpers for the PISO transmitter and the
//            matching parallel-register / SIPO receive path.
// Revision : 1.0 - initial release
// ============================================================================
package piso_tx_pkg;

   // Default word width shared with the parallel register and SIPO blocks
   localparam int c_default_width = 4;

   // FSM state encoding
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Ceiling log2, never less than 1 so a counter always has at least one bit
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/piso_tx_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Modulo-MOD up counter with synchronous clear and enable.
//            Wraps from MOD-1 to 0; holds when not enabled.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter
   import piso_tx_pkg::*;
#(
   parameter int MOD = c_default_width
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      enable,
   output logic [clog2(MOD)-1:0]     count,
   output logic                      at_max
);

   localparam int                c_cw  = clog2(MOD);
   localparam logic [c_cw-1:0]   c_max = c_cw'(MOD - 1);

   logic [c_cw-1:0] r_count;

   // Count enabled cycles modulo MOD; clear takes priority over enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= (r_count == c_max) ? '0 : r_count + c_cw'(1);
      end
   end

   assign count  = r_count;
   assign at_max = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx
// Purpose  : Parallel-in serial-out transmitter with a word-level valid/ready
//            handshake. Shifts one bit per clock, flags the first bit of each
//            frame and supports gapless back-to-back words.
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx
   import piso_tx_pkg::*;
#(
   parameter int WIDTH     = c_default_width,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int c_cw = clog2(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic             r_frame_start;
   logic [c_cw-1:0]  w_cnt;
   logic             w_cnt_at_max;
   logic             w_accept;
   logic [WIDTH-1:0] w_shifted;
   logic             w_out_bit;

   // A new word may enter when idle or while the last bit of the current
   // word is on the line, which is what makes back-to-back words gapless.
   assign load_ready = (r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_cnt_at_max);
   assign w_accept   = load_valid && load_ready;

   // Bit position within the word; reloading restarts it at zero
   mod_counter #(
      .MOD    (WIDTH)
   ) u_bit_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (w_accept),
      .enable (r_state == ST_SHIFT),
      .count  (w_cnt),
      .at_max (w_cnt_at_max)
   );

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_out_bit = r_shreg[WIDTH-1];
         assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_out_bit = r_shreg[0];
         assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      end
   endgenerate

   // Transmit FSM: loads, shifts and retires words; shreg is cleared when
   // idle so the output bit is naturally 0 outside a frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_shreg       <= '0;
         r_frame_start <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_shreg       <= parallel_in;
                  r_state       <= ST_SHIFT;
                  r_frame_start <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (w_cnt_at_max) begin
                  if (w_accept) begin
                     r_shreg       <= parallel_in;
                     r_frame_start <= 1'b1;
                  end else begin
                     r_shreg       <= '0;
                     r_state       <= ST_IDLE;
                     r_frame_start <= 1'b0;
                  end
               end else begin
                  r_shreg       <= w_shifted;
                  r_frame_start <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_shreg       <= '0;
               r_frame_start <= 1'b0;
            end
         endcase
      end
   end

   assign serial_out   = w_out_bit;
   assign serial_valid = (r_state == ST_SHIFT);
   assign busy         = (r_state == ST_SHIFT);
   assign frame_start  = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx
// Purpose  : Self-checking bench for piso_tx. Three instances cover the
//            4-bit MSB-first, 4-bit LSB-first and 8-bit LSB-first builds.
//            Expected serial bits are queued when a word is offered for
//            acceptance and popped as the DUT presents valid bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

   typedef struct packed {
      logic b;
      logic fs;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   logic [3:0] pin_a, pin_l;
   logic [7:0] pin_w;
   logic       lv_a, lv_l, lv_w;
   logic       lr_a, so_a, sv_a, fs_a, bz_a;
   logic       lr_l, so_l, sv_l, fs_l, bz_l;
   logic       lr_w, so_w, sv_w, fs_w, bz_w;

   exp_t q_a[$];
   exp_t q_l[$];
   exp_t q_w[$];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .reset(reset), .parallel_in(pin_a), .load_valid(lv_a),
      .load_ready(lr_a), .serial_out(so_a), .serial_valid(sv_a),
      .frame_start(fs_a), .busy(bz_a));

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .parallel_in(pin_l), .load_valid(lv_l),
      .load_ready(lr_l), .serial_out(so_l), .serial_valid(sv_l),
      .frame_start(fs_l), .busy(bz_l));

   piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_w (
      .clk(clk), .reset(reset), .parallel_in(pin_w), .load_valid(lv_w),
      .load_ready(lr_w), .serial_out(so_w), .serial_valid(sv_w),
      .frame_start(fs_w), .busy(bz_w));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue the expected bit sequence of one word for instance id
   task automatic push_word(input int id, input int w, input bit msb, input logic [7:0] word);
      exp_t e;
      for (int i = 0; i < w; i++) begin
         e.b  = msb ? word[w-1-i] : word[i];
         e.fs = (i == 0);
         case (id)
            0:       q_a.push_back(e);
            1:       q_l.push_back(e);
            default: q_w.push_back(e);
         endcase
      end
   endtask

   // Compare one instance's outputs against the head of its queue
   task automatic mon(input int id, input logic sv, input logic so, input logic fs, input logic bz);
      exp_t e;
      int   n;
      n = (id == 0) ? q_a.size() : (id == 1) ? q_l.size() : q_w.size();
      chk($sformatf("busy_eq_valid[%0d]", id), {31'd0, bz}, {31'd0, sv});
      if (sv === 1'b1) begin
         chk($sformatf("extra_bit[%0d]", id), (n > 0) ? 32'd1 : 32'd0, 32'd1);
         if (n > 0) begin
            case (id)
               0:       e = q_a.pop_front();
               1:       e = q_l.pop_front();
               default: e = q_w.pop_front();
            endcase
            chk($sformatf("serial_out[%0d]", id), {31'd0, so}, {31'd0, e.b});
            chk($sformatf("frame_start[%0d]", id), {31'd0, fs}, {31'd0, e.fs});
         end
      end else begin
         chk($sformatf("idle_out[%0d]", id), {30'd0, so, fs}, 32'd0);
         chk($sformatf("missing_bit[%0d]", id), n, 32'd0);
      end
   endtask

   // One clock: edge, settle, then check every instance
   task automatic tick();
      @(posedge clk);
      #1;
      mon(0, sv_a, so_a, fs_a, bz_a);
      mon(1, sv_l, so_l, fs_l, bz_l);
      mon(2, sv_w, so_w, fs_w, bz_w);
   endtask

   initial begin
      // 1. Reset with a word presented: nothing may be accepted
      reset = 1'b1;
      lv_a = 1'b1; pin_a = 4'b1111;
      lv_l = 1'b0; pin_l = 4'b0000;
      lv_w = 1'b0; pin_w = 8'h00;
      #7;
      chk("rst_outputs", {28'd0, so_a, sv_a, fs_a, bz_a}, 32'd0);
      chk("rst_load_ready", {31'd0, lr_a}, 32'd1);
      #3;
      reset = 1'b0;
      lv_a  = 1'b0;
      tick();
      chk("post_rst_idle", {31'd0, sv_a}, 32'd0);
      chk("post_rst_ready", {31'd0, lr_a}, 32'd1);

      // 2. Single word MSB-first
      lv_a = 1'b1; pin_a = 4'b1010;
      push_word(0, 4, 1'b1, 8'h0A);
      tick();
      lv_a = 1'b0;
      chk("ready_low_bit0", {31'd0, lr_a}, 32'd0);
      tick(); tick(); tick();
      chk("ready_high_last", {31'd0, lr_a}, 32'd1);
      tick();
      chk("idle_after_word", {31'd0, sv_a}, 32'd0);
      chk("ready_after_word", {31'd0, lr_a}, 32'd1);

      // 3. Back-to-back words with no gap
      lv_a = 1'b1; pin_a = 4'b1010;
      push_word(0, 4, 1'b1, 8'h0A);
      tick();
      pin_a = 4'b0101;
      tick(); tick();
      chk("b2b_held_off", {31'd0, lr_a}, 32'd0);
      tick();
      chk("b2b_ready_last", {31'd0, lr_a}, 32'd1);
      push_word(0, 4, 1'b1, 8'h05);
      tick();
      lv_a = 1'b0;
      tick(); tick(); tick();
      tick();
      chk("b2b_idle", {31'd0, sv_a}, 32'd0);

      // 4. Load pulse while busy is ignored
      lv_a = 1'b1; pin_a = 4'b1100;
      push_word(0, 4, 1'b1, 8'h0C);
      tick();
      lv_a = 1'b0;
      tick();
      chk("ignored_ready", {31'd0, lr_a}, 32'd0);
      lv_a = 1'b1; pin_a = 4'b0011;
      tick();
      lv_a = 1'b0;
      tick();
      tick();
      chk("ignored_idle", {31'd0, sv_a}, 32'd0);

      // 5. Asynchronous reset mid-frame
      lv_a = 1'b1; pin_a = 4'b1111;
      push_word(0, 4, 1'b1, 8'h0F);
      tick();
      lv_a = 1'b0;
      tick(); tick();
      #3;
      reset = 1'b1;
      #1;
      chk("midrst_outputs", {28'd0, so_a, sv_a, fs_a, bz_a}, 32'd0);
      chk("midrst_ready", {31'd0, lr_a}, 32'd1);
      q_a.delete();
      @(negedge clk);
      reset = 1'b0;
      tick();
      lv_a = 1'b1; pin_a = 4'b0001;
      push_word(0, 4, 1'b1, 8'h01);
      tick();
      lv_a = 1'b0;
      tick(); tick(); tick();
      tick();

      // 6a. LSB-first, 4 bits
      lv_l = 1'b1; pin_l = 4'b1010;
      push_word(1, 4, 1'b0, 8'h0A);
      tick();
      lv_l = 1'b0;
      tick(); tick(); tick();
      tick();
      chk("lsb_idle", {31'd0, sv_l}, 32'd0);

      // 6b. LSB-first, 8 bits
      lv_w = 1'b1; pin_w = 8'hA5;
      push_word(2, 8, 1'b0, 8'hA5);
      tick();
      lv_w = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
      end
      chk("w8_ready_last", {31'd0, lr_w}, 32'd1);
      tick();
      chk("w8_idle", {31'd0, sv_w}, 32'd0);

      chk("queues_drained", q_a.size() + q_l.size() + q_w.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
